// File: rtl/jpeg_reduce_pkg.sv
// Shared definitions for the jpeg_reduce pipeline: reduction modes, size limits
// and the popcount-width helper.
package jpeg_reduce_pkg;

  typedef enum logic [1:0] {
    MODE_XOR = 2'd0,
    MODE_MAJ = 2'd1,
    MODE_OR  = 2'd2
  } mode_e;

  localparam int MAX_NUM_IN      = 64;
  localparam int MAX_PIPE_STAGES = 6;

  function automatic int popcnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/jpeg_reduce_stage.sv
// One pipeline stage: folds operand bits [LO, HI) into the running partial result.
// With JPEG_REDUCE_POPCNT_EN defined it also carries a running popcount.
module jpeg_reduce_stage
  import jpeg_reduce_pkg::*;
#(
  parameter int    NUM_IN = 35,
  parameter int    ACC_W  = 1,
  parameter int    LO     = 0,
  parameter int    HI     = 35,
  parameter mode_e MODE   = MODE_XOR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold,
  input  logic                          in_valid,
  input  logic [NUM_IN-1:0]             in_data,
  input  logic [ACC_W-1:0]              in_acc,
`ifdef JPEG_REDUCE_POPCNT_EN
  input  logic [popcnt_w(NUM_IN)-1:0]   in_pc,
  output logic [popcnt_w(NUM_IN)-1:0]   out_pc,
`endif
  output logic                          out_valid,
  output logic [NUM_IN-1:0]             out_data,
  output logic [ACC_W-1:0]              out_acc
);

  logic              valid_q, valid_d;
  logic [NUM_IN-1:0] data_q, data_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  part;
  logic              load;

  assign load = !hold && in_valid;

  always_comb begin
    part = '0;
    for (int i = LO; i < HI; i++) begin
      case (MODE)
        MODE_MAJ: part = part + ACC_W'(in_data[i]);
        MODE_OR:  part = part | ACC_W'(in_data[i]);
        default:  part = part ^ ACC_W'(in_data[i]);
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    acc_d   = acc_q;
    if (hold) valid_d = valid_q;
    else      valid_d = in_valid;
    if (load) begin
      data_d = in_data;
      case (MODE)
        MODE_MAJ: acc_d = in_acc + part;
        MODE_OR:  acc_d = in_acc | part;
        default:  acc_d = in_acc ^ part;
      endcase
    end else begin
      data_d = data_q;
      acc_d  = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      acc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_acc   = acc_q;

`ifdef JPEG_REDUCE_POPCNT_EN
  localparam int PC_W = popcnt_w(NUM_IN);

  logic [PC_W-1:0] pc_q, pc_d, pc_part;

  always_comb begin
    pc_part = '0;
    for (int i = LO; i < HI; i++) pc_part = pc_part + PC_W'(in_data[i]);
    pc_d = pc_q;
    if (load) pc_d = in_pc + pc_part;
    else      pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign out_pc = pc_q;
`endif

endmodule

// File: rtl/jpeg_reduce_pipe.sv
// Pipelined XOR / majority / OR reduction of an NUM_IN-bit operand with a global stall.
// Optional out_popcnt port is enabled by defining JPEG_REDUCE_POPCNT_EN.
module jpeg_reduce_pipe
  import jpeg_reduce_pkg::*;
#(
  parameter int    NUM_IN      = 35,
  parameter int    PIPE_STAGES = 3,
  parameter mode_e MODE        = MODE_XOR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        out_bit,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 out_count
`ifdef JPEG_REDUCE_POPCNT_EN
  ,
  output logic [popcnt_w(NUM_IN)-1:0] out_popcnt
`endif
);

  localparam int PW    = popcnt_w(NUM_IN);
  localparam int ACC_W = (MODE == MODE_MAJ) ? PW : 1;
  localparam int HALF  = NUM_IN / 2;

  logic              valid_s [PIPE_STAGES+1];
  logic [NUM_IN-1:0] data_s  [PIPE_STAGES+1];
  logic [ACC_W-1:0]  acc_s   [PIPE_STAGES+1];
  logic              stall;
  logic [15:0]       count_q, count_d;

  assign valid_s[0] = in_valid;
  assign data_s[0]  = in_data;
  assign acc_s[0]   = '0;

  // No skid buffer: a blocked output freezes every stage and the input at once.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !out_valid || out_ready;

`ifdef JPEG_REDUCE_POPCNT_EN
  logic [PW-1:0] pc_s [PIPE_STAGES+1];
  assign pc_s[0]    = '0;
  assign out_popcnt = pc_s[PIPE_STAGES];
`endif

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    jpeg_reduce_stage #(
      .NUM_IN (NUM_IN),
      .ACC_W  (ACC_W),
      .LO     (s * NUM_IN / PIPE_STAGES),
      .HI     ((s + 1) * NUM_IN / PIPE_STAGES),
      .MODE   (MODE)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .hold      (stall),
      .in_valid  (valid_s[s]),
      .in_data   (data_s[s]),
      .in_acc    (acc_s[s]),
`ifdef JPEG_REDUCE_POPCNT_EN
      .in_pc     (pc_s[s]),
      .out_pc    (pc_s[s+1]),
`endif
      .out_valid (valid_s[s+1]),
      .out_data  (data_s[s+1]),
      .out_acc   (acc_s[s+1])
    );
  end

  assign out_valid = valid_s[PIPE_STAGES];

  always_comb begin
    out_bit = 1'b0;
    case (MODE)
      MODE_MAJ: out_bit = (acc_s[PIPE_STAGES] > ACC_W'(HALF));
      default:  out_bit = acc_s[PIPE_STAGES][0];
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready) count_d = count_q + 16'd1;
    else                        count_d = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= 16'd0;
    else     count_q <= count_d;
  end

  assign out_count = count_q;

endmodule

// File: doc/jpeg_reduce_pipe.md
JPEG_REDUCE_PIPE -- requirements
Module: jpeg_reduce_pipe

Interface
REQ-001 Parameter NUM_IN, default 35: number of single-bit data inputs, legal range 2..64.
REQ-002 Parameter PIPE_STAGES, default 3: number of register stages between input and output, legal range 1..6.
REQ-003 Parameter MODE, default MODE_XOR: reduction function, one of MODE_XOR, MODE_MAJ or MODE_OR.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port in_data, input, NUM_IN bits: operand vector.
REQ-007 Port in_valid, input, 1 bit: in_data holds a valid operand.
REQ-008 Port in_ready, output, 1 bit: block accepts the operand this cycle.
REQ-009 Port out_bit, output, 1 bit: reduction result.
REQ-010 Port out_valid, output, 1 bit: out_bit is valid.
REQ-011 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 Port out_count, output, 16 bits: number of results accepted downstream.

Function
REQ-013 Reduction, MODE_XOR: out_bit is the XOR of all NUM_IN bits.
REQ-014 Reduction, MODE_MAJ: out_bit is 1 when popcount(in_data) > NUM_IN/2 (integer division); a tie on even NUM_IN gives 0.
REQ-015 Reduction, MODE_OR: out_bit is the OR of all NUM_IN bits.
REQ-016 Input transfer: occurs when in_valid && in_ready are both high on a rising edge.
REQ-017 Output transfer: occurs when out_valid && out_ready are both high on a rising edge.
REQ-018 Latency: with no stall, a result appears on out_valid/out_bit exactly PIPE_STAGES cycles after its input transfer.
REQ-019 Throughput: with no stall, one operand is accepted per cycle.
REQ-020 Stall condition: every stage holds its contents when out_valid=1 and out_ready=0.
REQ-021 Ready rule: in_ready = !out_valid || out_ready, combinational; this gives a global stall with no skid buffer.
REQ-022 Valid bubbles: each stage carries its own valid bit and advances through holes without data loss.
REQ-023 Ordering: results are produced in input order; none are dropped or duplicated.
REQ-024 Output stability: out_bit is held stable while out_valid=1 and out_ready=0.
REQ-025 Partial sums: for PIPE_STAGES greater than 1, the reduction tree is split as evenly as possible across the stages.
REQ-026 Partial-sum width: in MODE_MAJ, partial popcounts are carried at $clog2(NUM_IN+1) bits.
REQ-027 Counter: out_count increments by 1 on each output transfer and wraps from 0xFFFF to 0x0000.
REQ-028 Simultaneous events: an input transfer and an output transfer in the same cycle both complete.

Reset
REQ-029 While rst=1: all stage valid bits clear, out_valid=0, out_bit=0, out_count=0, and in_ready=1.
REQ-030 Reset mid-operation: a rst pulse discards all in-flight operands; the first result after reset belongs to the first operand accepted after rst falls.

Configuration
REQ-031 Macro JPEG_REDUCE_POPCNT_EN defined: adds output port out_popcnt, $clog2(NUM_IN+1) bits, holding the popcount of the operand that produced the current out_bit.
REQ-032 out_popcnt timing: it has the same latency, stall behaviour and reset value (0) as out_bit, in every MODE.
REQ-033 Macro JPEG_REDUCE_POPCNT_EN absent: the port and its pipeline registers do not exist, and MODE_XOR and MODE_OR carry no popcount logic.

Structure
REQ-034 Shared package jpeg_reduce_pkg holds the mode enumeration (MODE_XOR, MODE_MAJ, MODE_OR).
REQ-035 jpeg_reduce_pkg also holds the constants MAX_NUM_IN=64 and MAX_PIPE_STAGES=6, and a popcount-width function.
REQ-036 Sub-module: one instance type, jpeg_reduce_stage, forms each pipeline stage.
REQ-037 jpeg_reduce_stage contents: a slice of partial reduction, a valid register and a hold-enable; the top generates PIPE_STAGES instances of it.

Verification
REQ-038 Streaming: NUM_IN=35, MODE_XOR, PIPE_STAGES=3, out_ready=1; apply in_data=35'h1 then 35'h3 on back-to-back cycles -> out_bit=1 at cycle 3, out_bit=0 at cycle 4, out_count=2.
REQ-039 Majority tie: NUM_IN=4, MODE_MAJ, PIPE_STAGES=1; apply 4'b0011, then 4'b0111 -> out_bit=0, then out_bit=1.
REQ-040 Stall: MODE_OR; apply 8 operands with out_ready=0 for cycles 4..9 -> in_ready=0 during the stall, out_bit held, and all 8 results delivered in order once out_ready=1.
REQ-041 Bubbles: in_valid toggles 1,0,1,0 -> out_valid shows the same pattern delayed by PIPE_STAGES cycles.
REQ-042 Counter wrap: preload 0xFFFF transfers (or force out_count=0xFFFF) and apply one more transfer -> out_count=0x0000.
REQ-043 Mid-flight reset: assert rst for one cycle while 3 operands are in flight -> out_valid=0 the next cycle, no stale results emerge, and with JPEG_REDUCE_POPCNT_EN defined out_popcnt=0.
